// File: rtl/uart_pkg.sv
// Shared UART definitions: the state encoding common to uart_tx and uart_rx,
// and the bit-period helper.
package uart_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE      = 2'b00;
  localparam state_t START_BIT = 2'b01;
  localparam state_t DATA_BIT  = 2'b10;
  localparam state_t STOP_BIT  = 2'b11;

  // Number of system clock cycles in one bit period.
  function automatic int calc_t_baud(input int seq, input int baud_rate);
    return seq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pin, plus the falling-edge
// detector used to spot a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic RX,
  output logic rx_s,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Idle-high reset values keep a reset from looking like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= RX;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_s = sync_q;
  assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-edge detect, mid-bit sampling of n data bits LSB
// first, stop-bit check with a done pulse or a framing-error pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SEQ       = 100000000,
  parameter int BAUD_RATE = 9600,
  parameter int n         = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         RX,
  output logic [n-1:0] data_out,
  output logic         rd_done,
  output logic         frame_err,
  output logic         busy
);

  localparam int T_BAUD = calc_t_baud(SEQ, BAUD_RATE);
  localparam int CW     = $clog2(T_BAUD);
  localparam int IW     = (n > 1) ? $clog2(n) : 1;

  localparam logic [CW-1:0] HALF = CW'(T_BAUD / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(T_BAUD - 1);
  localparam logic [IW-1:0] LAST = IW'(n - 1);

  if (T_BAUD < 4) begin : g_bad_baud
    $fatal(1, "uart_rx: SEQ/BAUD_RATE must be at least 4");
  end

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .RX   (RX),
    .rx_s (rx_s),
    .fall (fall)
  );

  state_t        state_q,     state_d;
  logic [CW-1:0] count_q,     count_d;
  logic [IW-1:0] index_q,     index_d;
  logic [n-1:0]  shift_q,     shift_d;
  logic [n-1:0]  data_q,      data_d;
  logic          rd_done_q,   rd_done_d;
  logic          frame_err_q, frame_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      index_q     <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      rd_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      index_q     <= index_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      rd_done_q   <= rd_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    index_d     = index_q;
    shift_d     = shift_q;
    data_d      = data_q;
    rd_done_d   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        index_d = '0;
        if (fall) state_d = START_BIT;
      end
      START_BIT: begin
        // A start bit that is high again by mid-bit was only a glitch.
        if (count_q == HALF) begin
          count_d = '0;
          state_d = rx_s ? IDLE : DATA_BIT;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      DATA_BIT: begin
        if (count_q == FULL) begin
          count_d          = '0;
          shift_d[index_q] = rx_s;
          if (index_q == LAST) begin
            index_d = '0;
            state_d = STOP_BIT;
          end else begin
            index_d = index_q + 1'b1;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      STOP_BIT: begin
        // Leaving at mid-stop-bit leaves half a bit of slack for the next start edge.
        if (count_q == FULL) begin
          count_d = '0;
          state_d = IDLE;
          if (rx_s) begin
            data_d    = shift_q;
            rd_done_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        index_d = '0;
      end
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  assign data_out  = data_q;
  assign rd_done   = rd_done_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: clean frames, back-to-back
// frames, glitch rejection, framing error and break, mid-frame reset, skew.
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       RX;
  logic [7:0] data_out;
  logic       rd_done;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .SEQ       (1600),
    .BAUD_RATE (100),
    .n         (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .data_out  (data_out),
    .rd_done   (rd_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // Drive at negedge N: rx_s falls two edges later (E), pulse registered at E+153.
  localparam int PULSE_LAT = 2 + 153;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int         rd_cnt   = 0;
  int         fe_cnt   = 0;
  int         busy_cnt = 0;
  int         rd_cyc [0:63];
  logic [7:0] rd_dat [0:63];
  int         fe_cyc   = -1;

  always @(negedge clk) begin
    if (rd_done) begin
      if (rd_cnt < 64) begin
        rd_cyc[rd_cnt] = cyc;
        rd_dat[rd_cnt] = data_out;
      end
      rd_cnt++;
    end
    if (frame_err) begin
      fe_cyc = cyc;
      fe_cnt++;
    end
    if (busy) busy_cnt++;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives the first nbits slots of a frame (start, 8 data LSB first, stop), p clocks each.
  task automatic send(input logic [7:0] d, input logic stop, input int p, input int nbits,
                      output int t0);
    logic [9:0] frame;
    frame = {stop, d, 1'b0};
    t0 = cyc;
    for (int b = 0; b < nbits; b++) begin
      RX = frame[b];
      repeat (p) @(negedge clk);
    end
  endtask

  task automatic idle(input int c);
    RX = 1'b1;
    repeat (c) @(negedge clk);
  endtask

  int t0, t1;
  int rd0, fe0, busy0;

  initial begin
    rst = 1'b1;
    RX  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_data_out",  32'(data_out),  32'h00);
    check("reset_rd_done",   32'(rd_done),   32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_busy",      32'(busy),      32'h0);
    idle(10);

    // Single clean frame.
    rd0 = rd_cnt; fe0 = fe_cnt;
    send(8'hA5, 1'b1, 16, 10, t0);
    idle(20);
    check("a5_rd_count",  32'(rd_cnt - rd0), 32'd1);
    check("a5_rd_cycle",  32'(rd_cyc[rd0] - t0), 32'(PULSE_LAT));
    check("a5_data_out",  32'(data_out), 32'hA5);
    check("a5_no_ferr",   32'(fe_cnt - fe0), 32'd0);

    // Back-to-back frames, second start right after the first stop.
    rd0 = rd_cnt;
    send(8'h00, 1'b1, 16, 10, t0);
    send(8'hFF, 1'b1, 16, 10, t1);
    idle(20);
    check("b2b_rd_count",  32'(rd_cnt - rd0), 32'd2);
    check("b2b_first_cyc", 32'(rd_cyc[rd0] - t0), 32'(PULSE_LAT));
    check("b2b_spacing",   32'(rd_cyc[rd0 + 1] - rd_cyc[rd0]), 32'd160);
    check("b2b_first_dat", 32'(rd_dat[rd0]), 32'h00);
    check("b2b_second_dat", 32'(rd_dat[rd0 + 1]), 32'hFF);

    // Four-cycle low glitch while idle.
    rd0 = rd_cnt; fe0 = fe_cnt; busy0 = busy_cnt;
    RX = 1'b0;
    repeat (4) @(negedge clk);
    idle(30);
    check("glitch_busy_cycles", 32'(busy_cnt - busy0), 32'd8);
    check("glitch_no_rd",       32'(rd_cnt - rd0), 32'd0);
    check("glitch_no_ferr",     32'(fe_cnt - fe0), 32'd0);
    check("glitch_data_kept",   32'(data_out), 32'hFF);

    // Stop bit low, then the line held low as a break.
    rd0 = rd_cnt; fe0 = fe_cnt;
    send(8'h3C, 1'b0, 16, 10, t0);
    RX = 1'b0;
    repeat (500) @(negedge clk);
    check("ferr_count",     32'(fe_cnt - fe0), 32'd1);
    check("ferr_cycle",     32'(fe_cyc - t0), 32'(PULSE_LAT));
    check("ferr_no_rd",     32'(rd_cnt - rd0), 32'd0);
    check("ferr_data_kept", 32'(data_out), 32'hFF);
    check("break_not_busy", 32'(busy), 32'h0);
    idle(30);
    check("break_no_more_ferr", 32'(fe_cnt - fe0), 32'd1);

    // Reset during data bit 4 of 0x5A, then a clean 0x81.
    rd0 = rd_cnt; fe0 = fe_cnt;
    send(8'h5A, 1'b1, 16, 5, t0);
    RX = 1'b1;
    repeat (8) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_data_zero", 32'(data_out), 32'h00);
    check("midrst_not_busy",  32'(busy), 32'h0);
    idle(40);
    check("midrst_no_pulse", 32'(rd_cnt - rd0 + fe_cnt - fe0), 32'd0);
    send(8'h81, 1'b1, 16, 10, t0);
    idle(20);
    check("post_rst_rd_count", 32'(rd_cnt - rd0), 32'd1);
    check("post_rst_rd_cycle", 32'(rd_cyc[rd0] - t0), 32'(PULSE_LAT));
    check("post_rst_data",     32'(data_out), 32'h81);

    // Transmitter running slow: 17 clocks per bit.
    rd0 = rd_cnt; fe0 = fe_cnt;
    send(8'hC3, 1'b1, 17, 10, t0);
    idle(30);
    check("skew_rd_count", 32'(rd_cnt - rd0), 32'd1);
    check("skew_data",     32'(data_out), 32'hC3);
    check("skew_no_ferr",  32'(fe_cnt - fe0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver; the counterpart of the team's uart_tx. Shares its frame format: 1 start bit (low), n data bits LSB first, 1 stop bit (high), no parity.
- Recovers bytes from the asynchronous RX pin by mid-bit sampling, using a baud counter derived from the system clock.
- Sits at the chip pin boundary. Delivers each received word with a one-cycle done pulse and flags framing errors.

Parameters:
- SEQ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bit/s. Local t_baud = SEQ/BAUD_RATE. t_baud must be >= 4; enforce with an elaboration-time check.
- n, 8, data bits per frame.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- RX  in  1  asynchronous serial line, idle high.
- data_out  out  n  last correctly framed word; holds until the next good frame.
- rd_done  out  1  one-cycle pulse; data_out updated this cycle.
- frame_err  out  1  one-cycle pulse; stop bit sampled low, data discarded.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- One clock; synchronous active-high reset. No asynchronous logic except the RX input synchronizer.
- Reset values:
  - state = IDLE.
  - Synchronizer flops and rx_prev = 1.
  - count = 0, index = 0, shift register = 0.
  - data_out = 0, rd_done = 0, frame_err = 0, busy = 0.
- Synchronizer: RX passes through 2 flops to give rx_s.
- Start detect is edge-based: rx_prev holds rx_s from the previous cycle, and fall = rx_prev & ~rx_s. A line held low (break) therefore never retriggers.
- Counter: count is $clog2(t_baud) bits and counts 0..t_baud-1. half = t_baud/2 - 1 and full = t_baud - 1.
- FSM states: IDLE, START_BIT, DATA_BIT, STOP_BIT.
  - IDLE: count = 0, index = 0. On fall, go to START_BIT. Call the fall cycle E.
  - START_BIT: count increments each cycle. At count == half (cycle E + t_baud/2):
    - rx_s == 0: go to DATA_BIT, count = 0.
    - rx_s == 1: glitch; return to IDLE with no output pulse.
  - DATA_BIT: at count == full, shift[index] <= rx_s and count = 0.
    - index == n-1: go to STOP_BIT, index = 0.
    - Otherwise index increments.
    - Data bit k is sampled at cycle E + t_baud/2 + (k+1)*t_baud.
  - STOP_BIT: at count == full (cycle E + t_baud/2 + (n+1)*t_baud), return to IDLE.
    - rx_s == 1: data_out <= shift, rd_done = 1 for that single cycle.
    - rx_s == 0: frame_err = 1 for that single cycle; data_out unchanged.
  - Any illegal state encoding goes to IDLE.
- Timing: the FSM reaches IDLE at mid-stop-bit. This allows a back-to-back frame whose start edge falls up to half a bit after the nominal stop end.
- rd_done and frame_err are mutually exclusive and never assert in consecutive cycles from the same frame.
- Reset mid-frame: state returns to IDLE on the next edge and the partial word is dropped. data_out goes to 0 and no pulse is emitted.
- A fall while busy is ignored; the FSM is sampling, not edge-watching.

Decomposition:
- Package uart_pkg:
  - 2-bit state localparams IDLE=00, START_BIT=01, DATA_BIT=10, STOP_BIT=11, shared with uart_tx.
  - Function computing t_baud from SEQ and BAUD_RATE.
- Sub-module uart_rx_sync:
  - 2-flop synchronizer plus rx_prev and the fall-edge detect.
  - Ports clk, rst, RX, rx_s, fall.
- The FSM, counter and shift register stay in uart_rx.

Test Plan (SEQ=1600, BAUD_RATE=100, so t_baud=16, n=8):
- Single frame 0xA5 driven at 16 clk/bit, idle high before and after -> rd_done pulses once at E+153; data_out = 0xA5; frame_err stays 0.
- Back-to-back frames 0x00 then 0xFF, second start bit immediately after the first stop bit -> two rd_done pulses 160 cycles apart; data_out 0x00 then 0xFF.
- RX low pulse of 4 cycles in idle -> FSM returns to IDLE at E+8; no rd_done or frame_err; busy high for 8 cycles.
- Frame 0x3C with stop bit driven low -> frame_err pulse at E+153; data_out keeps its previous value. A line then held low for 500 cycles -> no further pulses until a new high-to-low edge.
- rst asserted at data bit 4 of 0x5A, then a clean 0x81 frame -> after reset data_out = 0 with no pulse; next frame gives rd_done with data_out = 0x81.
- Data bits sampled with the bit period stretched to 17 cycles (+6% skew) on frame 0xC3 -> still received as 0xC3.
